booth_mult_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiplier for signed two's-complement operands. It generalises the fixed 4-bit Q-register/shift-bit datapath into a full multiplier with the following parts:
- WIDTH-bit operands.
- Accumulator (A), multiplier (Q) and Q(-1) registers.
- An iteration counter.
- A control FSM with a start/busy/done handshake.

It sits between the operand source and the result consumer of the arithmetic unit. It retires one Booth step per clock.

---
 rtl/booth_pkg.sv | 34 +++
 rtl/booth_datapath.sv | 69 ++++++
 rtl/booth_mult_seq.sv | 98 +++++++++
 tb/tb_booth_mult_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier: FSM states, Booth step
// operations, datapath control codes and the recoding function.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  typedef enum logic [1:0] {
    DP_HOLD = 2'd0,
    DP_LOAD = 2'd1,
    DP_STEP = 2'd2
  } dp_ctrl_t;

  // {Q[0], Q(-1)}: 01 -> add M, 10 -> subtract M, 00/11 -> no operation
  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    booth_op_t op;
    case ({q0, q_m1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_datapath.sv
// A / Q / Q(-1) / M registers of the Booth multiplier; performs one
// add-or-subtract plus arithmetic right shift per STEP command.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  dp_ctrl_t           ctrl,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] aq_next
);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   a_sum;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  booth_op_t        op;

  always_comb begin
    op = booth_decode(q_q[0], qm1_q);
    case (op)
      BOOTH_ADD: a_sum = a_q + m_q;
      BOOTH_SUB: a_sum = a_q - m_q;
      default:   a_sum = a_q;
    endcase

    // Low 2*WIDTH bits of {A, Q} as they will be after this step's shift;
    // lets the top capture the product on the same edge as the last step.
    aq_next = {a_sum, q_q[WIDTH-1:1]};

    a_d   = a_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    m_d   = m_q;
    case (ctrl)
      DP_LOAD: begin
        a_d   = '0;
        q_d   = mplier_in;
        qm1_d = 1'b0;
        m_d   = {mcand_in[WIDTH-1], mcand_in};
      end
      DP_STEP: begin
        a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_d   = {a_sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      m_q   <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      qm1_q <= qm1_d;
      m_q   <= m_d;
    end
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: control FSM, iteration counter,
// product register and start/busy/done handshake around booth_datapath.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] aq_next;
  dp_ctrl_t           dp_ctrl;

  booth_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl     (dp_ctrl),
    .mcand_in (multiplicand),
    .mplier_in(multiplier),
    .aq_next  (aq_next)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    product_d = product_q;
    dp_ctrl   = DP_HOLD;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          count_d = CNT_W'(WIDTH);
          dp_ctrl = DP_LOAD;
        end
      end
      CALC: begin
        dp_ctrl = DP_STEP;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d   = DONE;
          product_d = aq_next;
        end
      end
      DONE: begin
        // A start here chains straight into the next run without an IDLE cycle
        if (start) begin
          state_d = CALC;
          count_d = CNT_W'(WIDTH);
          dp_ctrl = DP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: 8-bit and 4-bit instances, expected
// products queued at start and compared when done pulses.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, busy8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] p8;
  logic        start4, busy4, done4;
  logic [3:0]  m4, q4;
  logic [7:0]  p4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp8_q[$];
  logic [7:0]  exp4_q[$];
  logic [15:0] e8;
  logic [7:0]  e4;

  booth_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .multiplicand(m8),
    .multiplier(q8), .busy(busy8), .done(done8), .product(p8)
  );

  booth_mult_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .multiplicand(m4),
    .multiplier(q4), .busy(busy4), .done(done4), .product(p4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = $signed({{8{a[7]}}, a});
    sb = $signed({{8{b[7]}}, b});
    return 16'(sa * sb);
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] sa, sb;
    sa = $signed({{4{a[3]}}, a});
    sb = $signed({{4{b[3]}}, b});
    return 8'(sa * sb);
  endfunction

  // Scoreboard: every done pulse pops and compares one expected product
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (exp8_q.size() == 0) begin
        check("done8_unexpected", 64'(done8), 64'd0);
      end else begin
        e8 = exp8_q.pop_front();
        $display("txn w8 product=0x%04h expected=0x%04h", p8, e8);
        check("product8", 64'(p8), 64'(e8));
      end
    end
    if (rst_n && done4) begin
      if (exp4_q.size() == 0) begin
        check("done4_unexpected", 64'(done4), 64'd0);
      end else begin
        e4 = exp4_q.pop_front();
        $display("txn w4 product=0x%02h expected=0x%02h", p4, e4);
        check("product4", 64'(p4), 64'(e4));
      end
    end
  end

  task automatic go8(input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    m8 = m; q8 = q; start8 = 1'b1;
    exp8_q.push_back(ref8(m, q));
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic go4(input logic [3:0] m, input logic [3:0] q);
    @(negedge clk);
    m4 = m; q4 = q; start4 = 1'b1;
    exp4_q.push_back(ref4(m, q));
    @(posedge clk);
    #1 start4 = 1'b0;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done8 && cyc < 40);
    if (!done8) check("timeout8", 64'(done8), 64'd1);
  endtask

  task automatic wait_done4(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done4 && cyc < 40);
    if (!done4) check("timeout4", 64'(done4), 64'd1);
  endtask

  initial begin
    int cyc;
    int extra;
    rst_n = 1'b0;
    start8 = 1'b0; m8 = '0; q8 = '0;
    start4 = 1'b0; m4 = '0; q4 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_product8", 64'(p8), 64'd0);
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_product4", 64'(p4), 64'd0);
    rst_n = 1'b1;

    // 3 * 4 with exact latency: busy for 8 cycles, done on the 9th
    go8(8'd3, 8'd4);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("busy8_calc", 64'(busy8), 64'd1);
      check("done8_early", 64'(done8), 64'd0);
    end
    @(negedge clk);
    check("done8_latency", 64'(done8), 64'd1);
    check("busy8_in_done", 64'(busy8), 64'd0);
    @(negedge clk);
    check("done8_one_cycle", 64'(done8), 64'd0);
    check("product8_hold_idle", 64'(p8), 64'h000C);

    // Most-negative operands exercise the guard bit
    go8(8'h80, 8'h80);
    wait_done8(cyc);

    // 127 * -128, then back-to-back -1 * -1 started in the DONE cycle
    go8(8'h7F, 8'h80);
    wait_done8(cyc);
    check("done8_b2b_first", 64'(done8), 64'd1);
    start8 = 1'b1; m8 = 8'hFF; q8 = 8'hFF;
    exp8_q.push_back(ref8(8'hFF, 8'hFF));
    @(posedge clk);
    #1 start8 = 1'b0;
    @(negedge clk);
    check("busy8_b2b", 64'(busy8), 64'd1);
    check("product8_hold_calc", 64'(p8), 64'hC080);
    wait_done8(cyc);
    check("b2b_latency", 64'(cyc), 64'd8);
    check("product8_b2b", 64'(p8), 64'h0001);

    // start during CALC cycle 3 is ignored
    go8(8'd5, 8'd6);
    repeat (2) @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; m8 = 8'd100; q8 = 8'd100;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8(cyc);
    check("product8_ignored_start", 64'(p8), 64'd30);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("extra_done8", 64'(extra), 64'd0);

    // Asynchronous reset in CALC cycle 5
    go8(8'd9, 8'd10);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy8", 64'(busy8), 64'd0);
    check("async_rst_done8", 64'(done8), 64'd0);
    check("async_rst_product8", 64'(p8), 64'd0);
    exp8_q.delete();
    exp4_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("no_done_after_abort", 64'(extra), 64'd0);
    go8(8'hF9, 8'd13);
    wait_done8(cyc);
    check("product8_after_reset", 64'(p8), 64'hFFA5);

    // WIDTH=4: -8 * 7, done 5 cycles after the start edge
    go4(4'h8, 4'h7);
    wait_done4(cyc);
    check("latency4", 64'(cyc), 64'd5);
    check("product4_m8x7", 64'(p4), 64'hC8);

    // Full sweep of all 4-bit operand pairs, offset so order is not trivial
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        go4(4'((a * 7 + 3) % 16), 4'((b * 5 + 1) % 16));
        wait_done4(cyc);
      end
    end
    repeat (3) @(negedge clk);
    check("queue8_drained", 64'(exp8_q.size()), 64'd0);
    check("queue4_drained", 64'(exp4_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
